// File: rtl/div_bin2bcd_seq.sv
// div_bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that
//   sits behind the unsigned divider. One adjust or shift step per clock; a
//   conversion of an N-bit value takes 2N step cycles plus one DONE cycle.
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   in_valid  conversion request (divider ready flag; may stay high 2 cycles)
//   bin_in    unsigned binary value, sampled only at accept
//   bcd_out   packed BCD result, digit 0 in [3:0]; updated after the DONE cycle
//   busy      high from the cycle after accept through the DONE cycle
//   done      one-cycle pulse in the DONE cycle
//   ovf       (only with BIN2BCD_OVF_EN) set when significant BCD bits were
//             lost because NDIG digits are too few; updates with bcd_out
//
// Optional feature macro: BIN2BCD_OVF_EN
module div_bin2bcd_seq #(
  parameter int N    = 8,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [N-1:0]      bin_in,
  output logic [4*NDIG-1:0] bcd_out,
  output logic              busy,
  output logic              done
`ifdef BIN2BCD_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int              CW       = $clog2(N) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, DONE} state_e;

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic [N-1:0]        bin_q, bin_d;
  logic [4*NDIG-1:0]   bcd_q, bcd_d;
  logic [4*NDIG-1:0]   bcd_out_q, bcd_out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                accept;
`ifdef BIN2BCD_OVF_EN
  logic                lost_q, lost_d;
  logic                ovf_q, ovf_d;
`endif

  // One conversion per ready burst: armed drops on accept and only
  // re-arms once in_valid has been seen low.
  assign accept = (state_q == IDLE) && in_valid && armed_q;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bcd_out_d = bcd_out_q;
    cnt_d     = cnt_q;
`ifdef BIN2BCD_OVF_EN
    lost_d    = lost_q;
    ovf_d     = ovf_q;
`endif

    if (accept) begin
      armed_d = 1'b0;
    end else if (!in_valid) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
`ifdef BIN2BCD_OVF_EN
          lost_d  = 1'b0;
`endif
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        for (int unsigned d = 0; d < NDIG; d++) begin
          if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
          end
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {bcd_q[4*NDIG-2:0], bin_q[N-1]};
        bin_d = {bin_q[N-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
`ifdef BIN2BCD_OVF_EN
        if (bcd_q[4*NDIG-1]) begin
          lost_d = 1'b1;
        end
`endif
        state_d = (cnt_q == CNT_LAST) ? DONE : ADJUST;
      end
      DONE: begin
        bcd_out_d = bcd_q;
`ifdef BIN2BCD_OVF_EN
        ovf_d     = lost_q;
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      bin_q     <= '0;
      bcd_q     <= '0;
      bcd_out_q <= '0;
      cnt_q     <= '0;
`ifdef BIN2BCD_OVF_EN
      lost_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bcd_out_q <= bcd_out_d;
      cnt_q     <= cnt_d;
`ifdef BIN2BCD_OVF_EN
      lost_q    <= lost_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  // busy/done are pure state decodes, so they match a registered busy
  // that is set at accept and cleared at DONE.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_out_q;
`ifdef BIN2BCD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_div_bin2bcd_seq.sv
// Testbench for div_bin2bcd_seq: directed cases plus randomized values,
// checked against a decimal-digit reference model.
module tb_div_bin2bcd_seq;

  localparam int N = 8;
`ifdef BIN2BCD_OVF_EN
  localparam int NDIG = 2;
`else
  localparam int NDIG = 3;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [N-1:0]      bin_in;
  logic [4*NDIG-1:0] bcd_out;
  logic              busy;
  logic              done;
`ifdef BIN2BCD_OVF_EN
  logic              ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_bin2bcd_seq #(.N(N), .NDIG(NDIG)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done)
`ifdef BIN2BCD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of v, kept modulo 10^NDIG.
  function automatic logic [31:0] ref_bcd(input int v);
    int x;
    logic [31:0] r;
    x = v;
    r = '0;
    for (int d = 0; d < NDIG; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Issue one request with value v.
  //   hold     : number of cycles in_valid stays high (bin_in scrambled when it drops)
  //   pulse_at : if >0, raise in_valid for one cycle at that cycle (should be ignored)
  //   rst_at   : if >0, assert reset_n for one cycle so the reset edge ends that cycle
  task automatic convert(input int v, input int hold, input int pulse_at, input int rst_at);
    int first;
    int ndone;
    first = 0;
    ndone = 0;
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = N'(v);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_accept", 32'(busy), 32'd1);
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
      if (rst_at > 0 && i == rst_at + 1) begin
        check("busy_after_reset", 32'(busy), 32'd0);
        check("bcd_after_reset", 32'(bcd_out), 32'd0);
      end
      if (i == hold) begin
        in_valid = 1'b0;
        bin_in   = N'($urandom);
      end
      if (pulse_at > 0 && i == pulse_at - 1) begin
        in_valid = 1'b1;
        bin_in   = 8'd13;
      end
      if (pulse_at > 0 && i == pulse_at) in_valid = 1'b0;
      if (rst_at > 0 && i == rst_at - 1) reset_n = 1'b0;
      if (rst_at > 0 && i == rst_at) reset_n = 1'b1;
    end
    in_valid = 1'b0;
    if (rst_at > 0) begin
      check("no_done_on_reset", 32'(ndone), 32'd0);
      check("bcd_cleared", 32'(bcd_out), 32'd0);
    end else begin
      check("done_count", 32'(ndone), 32'd1);
      check("done_cycle", 32'(first), 32'd17);
      check("busy_idle", 32'(busy), 32'd0);
      check("bcd_value", 32'(bcd_out), ref_bcd(v));
`ifdef BIN2BCD_OVF_EN
      check("ovf_value", 32'(ovf), 32'(v >= pow10(NDIG)));
`endif
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bcd_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
`ifdef BIN2BCD_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    reset_n = 1'b1;

    convert(255, 1, 0, 0);
    convert(0,   1, 0, 0);
    convert(9,   1, 0, 0);
    convert(100, 1, 0, 0);
    convert(42,  2, 0, 0);
    convert(7,   2, 0, 0);
    convert(200, 1, 5, 0);
    convert(77,  1, 0, 6);
    convert(77,  1, 0, 0);
    // in_valid held through and past DONE: no second conversion
    convert(123, 22, 0, 0);
    convert(99,  1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      convert(int'($urandom_range(255, 0)), int'($urandom_range(2, 1)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_bin2bcd_seq.md
Name: div_bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter placed directly downstream of the unsigned division FSM.
- Consumes the divider quotient when the divider's completion flag pulses, then converts it with shift-and-add-3 (double dabble), one adjust or shift step per clock.
- Presents packed BCD digits to the display/readout logic with a one-cycle done pulse.

Parameters:
- N, 8, width of the binary input (matches divider width).
- NDIG, 3, number of BCD output digits; 3 covers N=8 fully.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request to convert; wired to divider ready.
- bin_in  input  N  unsigned binary value; wired to divider quotient.
- bcd_out  output  4*NDIG  packed BCD; digit 0 in bits [3:0].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- ovf  output  1  present only with the optional feature; see below.

Behaviour:
- Single clock. Reset is synchronous and active-low: sampled on the clk rising edge while reset_n=0.
- Reset values: bcd_out=0, busy=0, done=0, ovf=0, state=IDLE, armed=1, internal shift registers=0.
- Edge arming: the upstream ready flag stays high for 2 cycles.
  - Internal flag armed clears when a request is accepted.
  - armed sets on any cycle with in_valid=0.
  - A request is accepted only when state=IDLE, in_valid=1 and armed=1.
  - Result: one conversion per ready burst.
- States:
  - IDLE: on accept, bin_reg<=bin_in, bcd_reg<=0, cnt<=0, busy<=1, go ADJUST. Otherwise stay.
  - ADJUST: each 4-bit digit of bcd_reg that is >=5 gets +3. All digits are adjusted in parallel in one cycle. Go SHIFT.
  - SHIFT: {bcd_reg,bin_reg} shifts left by 1, and bcd_reg[0] receives bin_reg[N-1]. Then cnt<=cnt+1. If cnt==N-1 go DONE, else go ADJUST.
  - DONE: bcd_out<=bcd_reg, done=1 for this cycle only, busy<=0, go IDLE.
- Latency:
  - The accept edge is cycle 0. ADJUST/SHIFT occupy cycles 1..2N. done is high in cycle 2N+1 (17 for N=8).
  - bcd_out changes on the edge that ends the DONE cycle. It is stable from then until the next DONE.
  - The earliest next accept is the cycle after DONE, provided armed=1.
- busy is high from the cycle after accept through the DONE cycle.
- in_valid while busy is ignored and does not queue. It still sets armed if low.
- bin_in is sampled only at accept. Later changes to bin_in do not affect the conversion in progress.
- Truncation: if NDIG is too small, the high-order BCD bits shifted out are lost. The lower digits remain correct modulo 10^NDIG.
- Reset mid-conversion: returns to IDLE, clears bcd_out, busy=0, armed=1. No done pulse is emitted.
- Widths: the cnt width is ceil(log2(N))+1. All arithmetic is unsigned and modulo 4 bits per digit.

Optional Feature:
- Macro: BIN2BCD_OVF_EN.
- Defined:
  - Port ovf exists.
  - An internal sticky flag clears at accept.
  - The flag sets in SHIFT when bcd_reg[4*NDIG-1]==1 (a bit lost off the top).
  - ovf<=flag in DONE, so ovf updates together with bcd_out. ovf resets to 0.
- Undefined: port ovf and its logic are absent; truncation is silent.

Test Plan:
- N=8, NDIG=3: reset, then in_valid=1 for 1 cycle with bin_in=255 -> busy=1 from the next cycle, done=1 exactly in cycle 17, bcd_out=0x255, busy=0 after.
- bin_in=0 -> bcd_out=0x000 at cycle 17. Then bin_in=9 -> 0x009. Then bin_in=100 -> 0x100.
- in_valid held high 2 cycles (ready profile), bin_in=42 -> exactly one done pulse, bcd_out=0x042. A second 2-cycle burst after IDLE with bin_in=7 -> bcd_out=0x007.
- Accept bin_in=200, then pulse in_valid again at cycle 5 with bin_in=13 (after a low cycle) -> that pulse is ignored, bcd_out=0x200, single done.
- Accept bin_in=77, then drive reset_n=0 at cycle 6 for one cycle -> busy=0, bcd_out=0, no done. A fresh request with bin_in=77 -> bcd_out=0x077 at cycle 17 from its accept.
- BIN2BCD_OVF_EN defined, NDIG=2: bin_in=123 -> bcd_out=0x23, ovf=1. Then bin_in=99 -> bcd_out=0x99, ovf=0.
